// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, control enums and the ALU used by the multi-cycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} CpuState;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR} AluCmd;
    typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG} PcSel;
    typedef enum logic [1:0] {WB_ALU, WB_MDR, WB_PC4} WbSel;
    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} DstSel;

    // 32-bit wrapping ALU; SLT compares as signed two's complement
    function automatic logic [31:0] aluCompute(input AluCmd cmd, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] result;
        case (cmd)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            default: result = a ^ b;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mips_mc_fsm.sv
// Sequencer for the multi-cycle MIPS core: state register, instruction decode and
// per-state control strobes for the datapath held in the top level.
module mips_mc_fsm
    import mips_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       operandsEqual,
    input  logic       misaligned,
    input  logic       memReady,
    output CpuState    state,
    output logic       memReq,
    output logic       memWe,
    output logic       irLoad,
    output logic       abLoad,
    output logic       aluLoad,
    output logic       mdrLoad,
    output logic       regWrite,
    output logic       pcWrite,
    output logic       retire,
    output logic       aluSrcImm,
    output logic       immZeroExt,
    output AluCmd      aluCmd,
    output PcSel       pcSel,
    output WbSel       wbSel,
    output DstSel      dstSel
);

    CpuState nextState;
    logic isRAlu, isJr, isImmAlu, isLoad, isStore, isBranch, isJump, isJal, legal, branchTaken;

    // Classify the latched instruction; anything unmatched is illegal
    always_comb begin
        isRAlu   = 1'b0;
        isJr     = 1'b0;
        isImmAlu = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        isBranch = 1'b0;
        isJump   = 1'b0;
        isJal    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                isRAlu = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);
                isJr   = (funct == FN_JR);
            end
            OP_J:            isJump   = 1'b1;
            OP_JAL:          isJal    = 1'b1;
            OP_BEQ, OP_BNE:  isBranch = 1'b1;
            OP_ADDI, OP_XORI: isImmAlu = 1'b1;
            OP_LW:           isLoad   = 1'b1;
            OP_SW:           isStore  = 1'b1;
            default: ;
        endcase
        legal       = isRAlu | isJr | isImmAlu | isLoad | isStore | isBranch | isJump | isJal;
        branchTaken = (opcode == OP_BEQ) ? operandsEqual : !operandsEqual;
        // XORI is a logical immediate, so it takes the zero-extended form
        immZeroExt  = (opcode == OP_XORI);
        aluSrcImm   = !isRAlu;
        aluCmd      = ALU_ADD;
        if (opcode == OP_XORI)
            aluCmd = ALU_XOR;
        else if (isRAlu && funct == FN_SUB)
            aluCmd = ALU_SUB;
        else if (isRAlu && funct == FN_SLT)
            aluCmd = ALU_SLT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= nextState;
    end

    // Next-state and strobes; PC and retire only move on the final cycle of an instruction
    always_comb begin
        nextState = state;
        memReq    = 1'b0;
        memWe     = 1'b0;
        irLoad    = 1'b0;
        abLoad    = 1'b0;
        aluLoad   = 1'b0;
        mdrLoad   = 1'b0;
        regWrite  = 1'b0;
        pcWrite   = 1'b0;
        retire    = 1'b0;
        pcSel     = PC_SEQ;
        wbSel     = WB_ALU;
        dstSel    = DST_RT;
        case (state)
            FETCH: begin
                memReq = 1'b1;
                if (memReady) begin
                    irLoad    = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: begin
                abLoad = 1'b1;
                if (legal)
                    nextState = EXEC;
                else if (HALT_ON_ILLEGAL)
                    nextState = HALT;
                else begin
                    pcWrite   = 1'b1;
                    retire    = 1'b1;
                    nextState = FETCH;
                end
            end
            EXEC: begin
                if (isRAlu || isImmAlu) begin
                    aluLoad   = 1'b1;
                    nextState = WB;
                end else if (isLoad || isStore) begin
                    aluLoad   = 1'b1;
                    nextState = MEM;
                end else begin
                    pcWrite   = 1'b1;
                    retire    = 1'b1;
                    nextState = FETCH;
                    if (isBranch)
                        pcSel = branchTaken ? PC_BRANCH : PC_SEQ;
                    else if (isJr)
                        pcSel = PC_REG;
                    else begin
                        pcSel = PC_JUMP;
                        if (isJal) begin
                            regWrite = 1'b1;
                            dstSel   = DST_RA;
                            wbSel    = WB_PC4;
                        end
                    end
                end
            end
            MEM: begin
                if (misaligned) begin
                    if (HALT_ON_ILLEGAL)
                        nextState = HALT;
                    else begin
                        pcWrite   = 1'b1;
                        retire    = 1'b1;
                        nextState = FETCH;
                    end
                end else begin
                    memReq = 1'b1;
                    memWe  = isStore;
                    if (memReady) begin
                        if (isStore) begin
                            pcWrite   = 1'b1;
                            retire    = 1'b1;
                            nextState = FETCH;
                        end else begin
                            mdrLoad   = 1'b1;
                            nextState = WB;
                        end
                    end
                end
            end
            WB: begin
                regWrite  = 1'b1;
                dstSel    = isRAlu ? DST_RD : DST_RT;
                wbSel     = isLoad ? WB_MDR : WB_ALU;
                pcWrite   = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            default: nextState = HALT;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS core datapath (PC, IR, A/B, ALUOut, MDR, register file) sharing one
// ready/valid memory port for instruction fetch and data access.
module mips_multicycle_cpu
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              retire,
    output logic [31:0]       instr_count,
    output logic [ADDR_W-1:0] pc_dbg
);

    CpuState     state;
    AluCmd       aluCmd;
    PcSel        pcSel;
    WbSel        wbSel;
    DstSel       dstSel;
    logic        memReq, memWe, irLoad, abLoad, aluLoad, mdrLoad, regWrite, pcWrite;
    logic        aluSrcImm, immZeroExt, unusedShamt;

    logic [31:0]       ir, regA, regB, immExt, aluOut, mdr, instrCount;
    logic [ADDR_W-1:0] pc, pc4, nextPc;
    logic [31:0]       regs [0:31];
    logic [31:0]       readA, readB, aluB, writeData, pc4Ext, jumpTarget;
    logic [4:0]        rs, rt, rd, writeAddr;

    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign unusedShamt = ^ir[10:6];
    assign readA       = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign readB       = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign aluB        = aluSrcImm ? immExt : regB;
    assign pc4Ext      = 32'(pc4);
    assign jumpTarget  = {pc4Ext[31:28], ir[25:0], 2'b00};

    mips_mc_fsm #(
        .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
    ) fsm (
        .clk          (clk),
        .reset        (reset),
        .opcode       (ir[31:26]),
        .funct        (ir[5:0]),
        .operandsEqual(regA == regB),
        .misaligned   (aluOut[1:0] != 2'b00),
        .memReady     (mem_ready),
        .state        (state),
        .memReq       (memReq),
        .memWe        (memWe),
        .irLoad       (irLoad),
        .abLoad       (abLoad),
        .aluLoad      (aluLoad),
        .mdrLoad      (mdrLoad),
        .regWrite     (regWrite),
        .pcWrite      (pcWrite),
        .retire       (retire),
        .aluSrcImm    (aluSrcImm),
        .immZeroExt   (immZeroExt),
        .aluCmd       (aluCmd),
        .pcSel        (pcSel),
        .wbSel        (wbSel),
        .dstSel       (dstSel)
    );

    // Branch offsets and jump targets wrap modulo 2**ADDR_W
    always_comb begin
        case (pcSel)
            PC_BRANCH: nextPc = pc4 + ADDR_W'(immExt << 2);
            PC_JUMP:   nextPc = ADDR_W'(jumpTarget);
            PC_REG:    nextPc = ADDR_W'({regA[31:2], 2'b00});
            default:   nextPc = pc4;
        endcase
        case (dstSel)
            DST_RD:  writeAddr = rd;
            DST_RA:  writeAddr = REG_RA;
            default: writeAddr = rt;
        endcase
        case (wbSel)
            WB_MDR:  writeData = mdr;
            WB_PC4:  writeData = pc4Ext;
            default: writeData = aluOut;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC[ADDR_W-1:0];
            pc4        <= '0;
            ir         <= '0;
            regA       <= '0;
            regB       <= '0;
            immExt     <= '0;
            aluOut     <= '0;
            mdr        <= '0;
            instrCount <= '0;
        end else begin
            if (irLoad) begin
                ir  <= mem_rdata;
                pc4 <= pc + ADDR_W'(4);
            end
            if (abLoad) begin
                regA   <= readA;
                regB   <= readB;
                immExt <= immZeroExt ? {16'd0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
            end
            if (aluLoad)
                aluOut <= aluCompute(aluCmd, regA, aluB);
            if (mdrLoad)
                mdr <= mem_rdata;
            if (pcWrite)
                pc <= nextPc;
            if (retire)
                instrCount <= instrCount + 32'd1;
        end
    end

    // Register file keeps its contents across reset; $0 is never written
    always_ff @(posedge clk) begin
        if (regWrite && writeAddr != 5'd0)
            regs[writeAddr] <= writeData;
    end

    // Reset gates the port combinationally so an in-flight request vanishes at once
    assign mem_req     = memReq & ~reset;
    assign mem_we      = memWe & ~reset;
    assign mem_addr    = reset ? '0 : ((state == FETCH) ? pc : aluOut[ADDR_W-1:0]);
    assign mem_wdata   = reset ? '0 : regB;
    assign halted      = (state == HALT);
    assign instr_count = instrCount;
    assign pc_dbg      = pc;

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench for the multi-cycle MIPS core: small program in a word memory model
// with controllable wait states, checking timing, results, trap and reset behaviour.
module tb_mips_multicycle_cpu;

    logic        clk;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, halted, retire;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, instr_count, pc_dbg;
    logic        stallMem;
    logic [8:0]  wordIdx;

    bit [31:0] prog   [0:511];
    bit [31:0] dmem   [0:511];
    bit        dvalid [0:511];

    int checkCount = 0;
    int errorCount = 0;

    mips_multicycle_cpu #(
        .ADDR_W         (32),
        .RESET_PC       (32'h40),
        .HALT_ON_ILLEGAL(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .halted     (halted),
        .retire     (retire),
        .instr_count(instr_count),
        .pc_dbg     (pc_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stored words shadow the program image at the same index
    assign wordIdx   = mem_addr[10:2];
    assign mem_rdata = dvalid[wordIdx] ? dmem[wordIdx] : prog[wordIdx];
    assign mem_ready = mem_req && !stallMem;

    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ready) begin
            dmem[wordIdx]   <= mem_wdata;
            dvalid[wordIdx] <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit rstLevel, input bit stall);
        reset    = rstLevel;
        stallMem = stall;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called on an instruction's fetch cycle; latency counts that cycle
    task automatic waitForRetire(input string tag, input int expectedLatency);
        int n;
        n = 1;
        while (!retire && n < 50) begin
            nextCycle();
            n++;
        end
        checkOutput(tag, 32'(n), 32'(expectedLatency));
    endtask

    task automatic loadProgram();
        prog[16]  = 32'h20010005;   // 0x40 ADDI $1,$0,5
        prog[17]  = 32'h00211020;   // 0x44 ADD  $2,$1,$1
        prog[18]  = 32'hAC020008;   // 0x48 SW   $2,8($0)
        prog[19]  = 32'h8C030008;   // 0x4C LW   $3,8($0)
        prog[20]  = 32'h08000017;   // 0x50 J    0x5C
        prog[21]  = 32'h00000000;
        prog[22]  = 32'h0C000100;   // 0x58 JAL  0x400
        prog[23]  = 32'h1420FFFE;   // 0x5C BNE  $1,$0,-2
        prog[256] = 32'hAC1F000C;   // 0x400 SW  $31,12($0)
        prog[257] = 32'hAC030010;   // 0x404 SW  $3,16($0)
        prog[258] = 32'h3825000F;   // 0x408 XORI $5,$1,0xF
        prog[259] = 32'h00013822;   // 0x40C SUB $7,$0,$1
        prog[260] = 32'h00E1302A;   // 0x410 SLT $6,$7,$1
        prog[261] = 32'hAC050014;   // 0x414 SW  $5,20($0)
        prog[262] = 32'hAC070018;   // 0x418 SW  $7,24($0)
        prog[263] = 32'hAC06001C;   // 0x41C SW  $6,28($0)
        prog[264] = 32'hFC000000;   // 0x420 illegal opcode 0x3F
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] retMask;
        bit         anyReq, anyRetire, found;
        int         n;

        loadProgram();
        applyStimulus(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rstMemReq", 32'(mem_req), 32'd0);
        checkOutput("rstMemWe", 32'(mem_we), 32'd0);
        checkOutput("rstMemAddr", mem_addr, 32'd0);
        checkOutput("rstWdata", mem_wdata, 32'd0);
        checkOutput("rstHalted", 32'(halted), 32'd0);
        checkOutput("rstRetire", 32'(retire), 32'd0);
        checkOutput("rstCount", instr_count, 32'd0);
        checkOutput("rstPc", pc_dbg, 32'h40);

        // Cycle 1: first fetch from the reset vector
        applyStimulus(1'b0, 1'b0);
        checkOutput("firstReq", 32'(mem_req), 32'd1);
        checkOutput("firstAddr", mem_addr, 32'h40);

        retMask = '0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1)
                nextCycle();
            retMask[c-1] = retire;
        end
        checkOutput("retireCycles", 32'(retMask), 32'h88);
        nextCycle();
        checkOutput("countAfterAdd", instr_count, 32'd2);
        checkOutput("fetchSwAddr", mem_addr, 32'h48);

        // SW with three wait states: port must hold steady until accepted
        repeat (3) nextCycle();
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3)
                applyStimulus(1'b0, 1'b0);
            checkOutput("swReqWe", 32'({mem_req, mem_we}), 32'd3);
            checkOutput("swAddr", mem_addr, 32'h8);
            checkOutput("swWdata", mem_wdata, 32'd10);
            checkOutput("swRetire", 32'(retire), (k == 3) ? 32'd1 : 32'd0);
            if (k < 3)
                nextCycle();
        end
        nextCycle();
        checkOutput("swStored", dmem[2], 32'd10);
        checkOutput("fetchLwAddr", mem_addr, 32'h4C);
        waitForRetire("lwLatency", 5);
        nextCycle();
        checkOutput("fetchJAddr", mem_addr, 32'h50);
        waitForRetire("jLatency", 3);
        nextCycle();
        checkOutput("jTarget", pc_dbg, 32'h5C);
        waitForRetire("bneLatency", 3);
        nextCycle();
        checkOutput("bneTarget", pc_dbg, 32'h58);
        waitForRetire("jalLatency", 3);
        nextCycle();
        checkOutput("jalTarget", pc_dbg, 32'h400);

        n = 0;
        while (!halted && n < 300) begin
            nextCycle();
            n++;
        end
        checkOutput("halted", 32'(halted), 32'd1);
        checkOutput("haltPc", pc_dbg, 32'h420);
        checkOutput("haltCount", instr_count, 32'd15);
        checkOutput("jalLink", dmem[3], 32'h5C);
        checkOutput("lwValue", dmem[4], 32'd10);
        checkOutput("xoriValue", dmem[5], 32'd10);
        checkOutput("subValue", dmem[6], 32'hFFFFFFFB);
        checkOutput("sltValue", dmem[7], 32'd1);

        anyReq    = 1'b0;
        anyRetire = 1'b0;
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            anyReq    = anyReq | mem_req;
            anyRetire = anyRetire | retire;
        end
        checkOutput("haltNoReq", 32'(anyReq), 32'd0);
        checkOutput("haltNoRetire", 32'(anyRetire), 32'd0);
        checkOutput("haltPcFrozen", pc_dbg, 32'h420);
        checkOutput("haltSticky", 32'(halted), 32'd1);

        // Reset from HALT, then reset again in the middle of a stalled LW
        applyStimulus(1'b1, 1'b0);
        repeat (2) nextCycle();
        checkOutput("reRstCount", instr_count, 32'd0);
        checkOutput("reRstHalted", 32'(halted), 32'd0);
        applyStimulus(1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (mem_req && !mem_we && mem_addr == 32'h8)
                found = 1'b1;
            else
                nextCycle();
        end
        checkOutput("lwReached", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b1);
        nextCycle();
        checkOutput("lwStallReq", 32'(mem_req), 32'd1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("midRstReq", 32'(mem_req), 32'd0);
        checkOutput("midRstAddr", mem_addr, 32'd0);
        checkOutput("midRstCount", instr_count, 32'd0);
        checkOutput("midRstPc", pc_dbg, 32'h40);
        applyStimulus(1'b0, 1'b0);
        checkOutput("postRstFetchReq", 32'({mem_req, mem_we}), 32'd2);
        checkOutput("postRstFetchAddr", mem_addr, 32'h40);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
